sticker_collector: RTL

STICKER_COLLECTOR -- requirements
Module: sticker_collector

---
 rtl/sticker_collector.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/sticker_collector.sv
// Rubik's-face sticker collector: debounces classifier color samples into
// nine accepted stickers, with invalid-code and inter-sample timeout errors.
module sticker_collector #(
    parameter int STABLE_COUNT = 4,
    parameter int TIMEOUT      = 1000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        sample_valid,
    input  logic [2:0]  color,
    output logic        busy,
    output logic        sticker_ready,
    output logic        face_done,
    output logic [26:0] face,
    output logic [3:0]  sticker_idx,
    output logic        error
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2,
        ST_ERR     = 2'd3
    } state_t;

    localparam logic [3:0]  STABLE_LIM = 4'(STABLE_COUNT);
    // The timeout fires on the quiet cycle that would carry the count to TIMEOUT-1.
    localparam logic [15:0] TMO_LIM    = 16'(TIMEOUT - 2);
    localparam logic [3:0]  LAST_SLOT  = 4'd8;

    // Classifier codes 0..5 are real colors; 6 and 7 signal a classifier fault.
    function automatic logic color_ok(input logic [2:0] c);
        return (c <= 3'd5);
    endfunction

    state_t      state_r;
    logic        busy_r;
    logic        sticker_ready_r;
    logic        face_done_r;
    logic [26:0] face_r;
    logic [3:0]  idx_r;
    logic        error_r;
    logic [3:0]  run_r;
    logic [2:0]  last_r;
    logic [15:0] tmo_r;

    logic [3:0]  run_next_s;
    logic        accept_s;
    logic [26:0] face_upd_s;

    // Run length the current sample would produce if it is taken.
    always_comb begin
        run_next_s = 4'd1;
        if ((run_r != 4'd0) && (color == last_r)) begin
            run_next_s = run_r + 4'd1;
        end else begin
            run_next_s = 4'd1;
        end
    end

    assign accept_s = (run_next_s == STABLE_LIM);

    // Face image with the current slot overwritten by the incoming color.
    always_comb begin
        face_upd_s = face_r;
        for (int i = 0; i < 9; i++) begin
            if (idx_r == 4'(i)) begin
                face_upd_s[3*i +: 3] = color;
            end else begin
                face_upd_s[3*i +: 3] = face_r[3*i +: 3];
            end
        end
    end

    // Main control FSM; every output is a register updated here.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r         <= ST_IDLE;
            busy_r          <= 1'b0;
            sticker_ready_r <= 1'b0;
            face_done_r     <= 1'b0;
            face_r          <= 27'd0;
            idx_r           <= 4'd0;
            error_r         <= 1'b0;
            run_r           <= 4'd0;
            last_r          <= 3'd0;
            tmo_r           <= 16'd0;
        end else begin
            sticker_ready_r <= 1'b0;
            face_done_r     <= 1'b0;
            case (state_r)
                ST_IDLE, ST_ERR: begin
                    if (start) begin
                        state_r <= ST_CAPTURE;
                        busy_r  <= 1'b1;
                        error_r <= 1'b0;
                        face_r  <= 27'd0;
                        idx_r   <= 4'd0;
                        run_r   <= 4'd0;
                        last_r  <= 3'd0;
                        tmo_r   <= 16'd0;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_CAPTURE: begin
                    if (sample_valid) begin
                        tmo_r <= 16'd0;
                        if (!color_ok(color)) begin
                            state_r <= ST_ERR;
                            error_r <= 1'b1;
                            busy_r  <= 1'b0;
                        end else begin
                            last_r <= color;
                            if (accept_s) begin
                                face_r          <= face_upd_s;
                                idx_r           <= idx_r + 4'd1;
                                run_r           <= 4'd0;
                                sticker_ready_r <= 1'b1;
                                if (idx_r == LAST_SLOT) begin
                                    state_r     <= ST_DONE;
                                    face_done_r <= 1'b1;
                                    busy_r      <= 1'b0;
                                end else begin
                                    state_r <= ST_CAPTURE;
                                end
                            end else begin
                                run_r <= run_next_s;
                            end
                        end
                    end else if (tmo_r == TMO_LIM) begin
                        state_r <= ST_ERR;
                        error_r <= 1'b1;
                        busy_r  <= 1'b0;
                    end else begin
                        tmo_r <= tmo_r + 16'd1;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy          = busy_r;
    assign sticker_ready = sticker_ready_r;
    assign face_done     = face_done_r;
    assign face          = face_r;
    assign sticker_idx   = idx_r;
    assign error         = error_r;

endmodule
